// File: rtl/frame_pkg.sv
// Shared definitions for the frame sequencer and the channel frame buffer:
// sequencer state encoding, debug view and width-derivation helpers.
package frame_pkg;

    typedef enum logic [1:0] {
        s_idle  = 2'd0,
        s_copy  = 2'd1,
        s_flush = 2'd2
    } state_t;

    typedef struct packed {
        state_t state;
        logic   pending;
        logic   bank_last;
    } frame_dbg_t;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int c_def_ledboards    = 30;
    localparam int c_def_ch_per_board = 32;
    localparam int c_def_channels     = c_def_ledboards * c_def_ch_per_board;
    localparam int c_def_max_time     = 1024;
    localparam int c_def_banks        = 2;
    localparam int c_def_addr_w       = clog2_min1(c_def_channels);
    localparam int c_def_time_w       = clog2_min1(c_def_max_time);
    localparam int c_def_bank_w       = clog2_min1(c_def_banks);

endpackage

// File: rtl/wrap_counter.sv
// Modulo-c_max up-counter with enable, synchronous clear and terminal-count flag.
// Used for both the channel address sweep and the ping-pong bank index.
module wrap_counter #(
    parameter int c_max = 2,
    parameter int c_w   = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_en,
    input  logic           i_clr,
    output logic [c_w-1:0] o_count,
    output logic           o_tc
);

    localparam logic [c_w-1:0] c_last = c_w'(c_max - 1);

    assign o_tc = (o_count == c_last);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            o_count <= '0;
        end else if (i_en) begin
            o_count <= o_tc ? '0 : o_count + c_w'(1);
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: on a request, sweeps all channel addresses with a write strobe
// into the current bank, then flips banks; one request can be queued while busy.
module frame_sequencer
    import frame_pkg::*;
#(
    parameter int c_ledboards    = c_def_ledboards,
    parameter int c_ch_per_board = c_def_ch_per_board,
    parameter int c_max_time     = c_def_max_time,
    parameter int c_banks        = c_def_banks,
    parameter int c_channels     = c_ledboards * c_ch_per_board,
    parameter int c_addr_w       = clog2_min1(c_channels),
    parameter int c_time_w       = clog2_min1(c_max_time),
    parameter int c_bank_w       = clog2_min1(c_banks)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_drq,
    input  logic [c_time_w-1:0] i_target_time,
    input  logic                i_ready,
    output logic [c_addr_w-1:0] o_addr,
    output logic [c_bank_w-1:0] o_bank,
    output logic [c_time_w-1:0] o_start_time,
    output logic                o_wen,
    output logic                o_drq,
    output logic                o_busy,
    output logic                o_overrun,
    output frame_dbg_t          o_dbg
);

    // Handshake: a channel write is transferred in every cycle where o_wen && i_ready;
    // with i_ready low the address and strobe are held unchanged until accepted.

    state_t              state;
    logic                pending;
    logic [c_time_w-1:0] pend_time;
    logic                addr_tc;
    logic                bank_tc;
    logic                addr_en;
    logic                addr_clr;
    logic                bank_en;
    logic                serving;
    logic                queue_req;

    assign addr_en   = (state == s_copy) && i_ready && !addr_tc;
    assign addr_clr  = (state == s_flush);
    assign bank_en   = (state == s_flush);
    assign serving   = (state == s_idle) && pending;
    // A request is queued whenever it cannot start a frame immediately.
    assign queue_req = i_drq && ((state != s_idle) || pending);

    wrap_counter #(.c_max(c_channels), .c_w(c_addr_w)) u_addr_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (addr_en),
        .i_clr   (addr_clr),
        .o_count (o_addr),
        .o_tc    (addr_tc)
    );

    wrap_counter #(.c_max(c_banks), .c_w(c_bank_w)) u_bank_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (bank_en),
        .i_clr   (1'b0),
        .o_count (o_bank),
        .o_tc    (bank_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= s_idle;
            o_start_time <= '0;
            o_wen        <= 1'b0;
            o_drq        <= 1'b0;
            o_busy       <= 1'b0;
            o_overrun    <= 1'b0;
            pending      <= 1'b0;
            pend_time    <= '0;
        end else begin
            o_drq <= 1'b0;
            case (state)
                s_idle: begin
                    if (pending || i_drq) begin
                        state        <= s_copy;
                        o_wen        <= 1'b1;
                        o_busy       <= 1'b1;
                        o_start_time <= pending ? pend_time : i_target_time;
                    end
                end
                s_copy: begin
                    if (i_ready && addr_tc) begin
                        state <= s_flush;
                        o_wen <= 1'b0;
                        o_drq <= 1'b1;
                    end
                end
                s_flush: begin
                    state  <= s_idle;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= s_idle;
                    o_wen  <= 1'b0;
                    o_busy <= 1'b0;
                end
            endcase

            // The slot being served this cycle counts as empty for the new request.
            if (queue_req) begin
                pending   <= 1'b1;
                pend_time <= i_target_time;
                if (pending && !serving) begin
                    o_overrun <= 1'b1;
                end
            end else if (serving) begin
                pending <= 1'b0;
            end
        end
    end

    assign o_dbg = '{state: state, pending: pending, bank_last: bank_tc};

endmodule
